// File: rtl/pipe_skid_stage_pkg.sv
// pipe_pkg: shared types and defaults for the skid-buffered pipeline stage.
//   pipe_state_e    - occupancy of the stage (empty / one entry / both slots)
//   PIPE_CNT_W_DEF  - default width of the optional performance counters
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

    localparam int unsigned PIPE_CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_skid_stage_slot.sv
// pipe_slot: one WIDTH-bit data register of the skid stage.
//   clk, rst - clock, asynchronous active-high reset (clears to 0)
//   clr_i    - synchronous clear, wins over ld_i
//   ld_i     - load d_i at the next rising edge
//   d_i      - data in
//   q_o      - held data
module pipe_slot #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else if (clr_i) begin
            q_q <= '0;
        end else if (ld_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: pipeline register with valid/ready handshake, synchronous
// flush and a one-entry skid buffer. in_ready depends on state only.
//   clk, rst            - clock, asynchronous active-high reset
//   flush               - discard all held entries (drops a same-cycle input)
//   in_valid/in_data    - upstream payload, accepted when in_ready=1
//   in_ready            - stage can accept this cycle
//   out_valid/out_data  - payload to downstream, taken when out_ready=1
//   out_ready           - downstream accepts
//   stall_cnt/flush_cnt - saturating counters, present only when the macro
//                         PIPE_SKID_STAGE_PERF_EN is defined
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = PIPE_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef PIPE_SKID_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    pipe_state_e      state_q, state_d;
    logic             in_ready_q, out_valid_q;
    logic             in_fire, out_fire;
    logic             main_ld, skid_ld;
    logic [WIDTH-1:0] main_d, main_q, skid_q;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
        skid_ld = 1'b0;
        main_d  = in_data;
        case (state_q)
            PS_EMPTY: begin
                if (in_fire) begin
                    state_d = PS_ONE;
                    main_ld = 1'b1;
                end
            end
            PS_ONE: begin
                if (in_fire && out_fire) begin
                    main_ld = 1'b1;
                end else if (in_fire) begin
                    state_d = PS_FULL;
                    skid_ld = 1'b1;
                end else if (out_fire) begin
                    state_d = PS_EMPTY;
                end
            end
            PS_FULL: begin
                // Skid drains into main; in_ready is low so no input here.
                if (out_fire) begin
                    state_d = PS_ONE;
                    main_ld = 1'b1;
                    main_d  = skid_q;
                end
            end
            default: state_d = PS_EMPTY;
        endcase
        // Slot clears are driven by flush directly and win over loads.
        if (flush) begin
            state_d = PS_EMPTY;
        end
    end

    // Handshake outputs are registered decodes of the next state so they
    // always agree with state_q without a combinational path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PS_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != PS_FULL);
            out_valid_q <= (state_d != PS_EMPTY);
        end
    end

    pipe_slot #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .ld_i  (main_ld),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    pipe_slot #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .ld_i  (skid_ld),
        .d_i   (in_data),
        .q_o   (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

`ifdef PIPE_SKID_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush && (state_q != PS_EMPTY) && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
`ifdef PIPE_SKID_STAGE_PERF_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef PIPE_SKID_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         fl;
        logic         e_ov;
        logic         chk_d;
        logic [W-1:0] e_od;
        logic         e_ir;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [W-1:0] d, input logic ordy,
                                input logic fl, input logic e_ov, input logic chk_d,
                                input logic [W-1:0] e_od, input logic e_ir);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.e_ov = e_ov; v.chk_d = chk_d; v.e_od = e_od; v.e_ir = e_ir;
        return v;
    endfunction

    initial begin
        // Inputs are driven for the cycle; expected outputs are those seen
        // during that same cycle (before the edge that consumes the inputs).
        //             iv  d      ordy fl  ov chkd od     ir
        // back-to-back stream 0x11,0x22,0x33
        vecs.push_back(mk(1, 8'h11, 1, 0, 0, 1, 8'h00, 1));
        vecs.push_back(mk(1, 8'h22, 1, 0, 1, 1, 8'h11, 1));
        vecs.push_back(mk(1, 8'h33, 1, 0, 1, 1, 8'h22, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h33, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 1));
        // stream 0xA0..0xA3 with a single-cycle out_ready drop
        vecs.push_back(mk(1, 8'hA0, 1, 0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(1, 8'hA1, 1, 0, 1, 1, 8'hA0, 1));
        vecs.push_back(mk(1, 8'hA2, 0, 0, 1, 1, 8'hA1, 1));
        vecs.push_back(mk(1, 8'hA3, 1, 0, 1, 1, 8'hA1, 0));
        vecs.push_back(mk(1, 8'hA3, 1, 0, 1, 1, 8'hA2, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hA3, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 1));
        // fill to FULL with 0x5,0x6, then drain
        vecs.push_back(mk(1, 8'h05, 0, 0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(1, 8'h06, 0, 0, 1, 1, 8'h05, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h05, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h05, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h06, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 1));
        // fill to FULL, then flush together with in_valid/0x77
        vecs.push_back(mk(1, 8'h01, 0, 0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(1, 8'h02, 0, 0, 1, 1, 8'h01, 1));
        vecs.push_back(mk(1, 8'h77, 0, 1, 1, 1, 8'h01, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 8'h00, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 8'h00, 1));
        // flush while ONE and out_fire: word still delivered, then empty
        vecs.push_back(mk(1, 8'h3C, 1, 0, 0, 1, 8'h00, 1));
        vecs.push_back(mk(1, 8'h4D, 1, 1, 1, 1, 8'h3C, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 8'h00, 1));

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef PIPE_SKID_STAGE_PERF_EN
        chk("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        chk("rst_flush_cnt", {28'd0, flush_cnt}, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            flush     = vecs[i].fl;
            #1;
            chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
            if (vecs[i].chk_d)
                chk($sformatf("v%0d_out_data", i), {24'd0, out_data}, {24'd0, vecs[i].e_od});
            if (out_valid)
                chk($sformatf("v%0d_no_0x77", i), {31'd0, out_data == 8'h77}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

        // Asynchronous reset while holding 0x9 in ONE.
        in_valid = 1'b1; in_data = 8'h09;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("arst_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("arst_pre_data", {24'd0, out_data}, 32'h09);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_data", {24'd0, out_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_stay_empty", {31'd0, out_valid}, 32'd0);

`ifdef PIPE_SKID_STAGE_PERF_EN
        chk("perf_cnt_after_rst", {24'd0, stall_cnt, flush_cnt}, 32'd0);
        // Load one word, then flush while stalled: both counters step.
        in_valid = 1'b1; in_data = 8'h21;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("perf_flush_cnt_one", {28'd0, flush_cnt}, 32'd1);
        chk("perf_stall_on_flush", {28'd0, stall_cnt}, 32'd1);
        // Flush while empty leaves flush_cnt unchanged.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("perf_flush_empty", {28'd0, flush_cnt}, 32'd1);
        // 20 stalled cycles saturate stall_cnt at 15.
        in_valid = 1'b1; in_data = 8'h42;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 13)
                chk("perf_stall_14", {28'd0, stall_cnt}, 32'd15);
        end
        chk("perf_stall_sat", {28'd0, stall_cnt}, 32'd15);
        chk("perf_stall_held", {31'd0, out_valid}, 32'd1);
        chk("perf_stall_data", {24'd0, out_data}, 32'h42);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and a one-entry skid buffer. It is the successor to our plain resettable/clearable flop for inter-stage registers, and replaces stall-by-enable wiring between IF/ID/EX/MEM/WB. Full throughput is one transfer per cycle with one cycle of latency. `in_ready` is driven from state only, which breaks the combinational ready path between stages.

## Interface
- `WIDTH`, 32, payload width in bits (≥1)
- `CNT_W`, 16, performance counter width (used only with `PIPE_SKID_STAGE_PERF_EN`)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `flush`  in  1  synchronous flush, discards all held entries
- `in_valid`  in  1  upstream payload valid
- `in_data`  in  WIDTH  upstream payload
- `in_ready`  out  1  stage can accept this cycle
- `out_valid`  out  1  payload available downstream
- `out_data`  out  WIDTH  payload to downstream
- `out_ready`  in  1  downstream accepts
- `stall_cnt`  out  CNT_W  cycles with out_valid=1 and out_ready=0 (`PIPE_SKID_STAGE_PERF_EN` only)
- `flush_cnt`  out  CNT_W  flushes that discarded ≥1 entry (`PIPE_SKID_STAGE_PERF_EN` only)

## Operation
- Storage: `main` slot, which drives `out_data`, and `skid` slot. Each slot holds WIDTH data bits.
- `in_fire` = in_valid & in_ready. `out_fire` = out_valid & out_ready.
- State register, with three states:
  - EMPTY: `in_fire` → ONE, main←in_data.
  - ONE:
    - `in_fire` & `out_fire` → ONE, main←in_data.
    - `in_fire` & !`out_fire` → FULL, skid←in_data.
    - !`in_fire` & `out_fire` → EMPTY.
    - Otherwise hold.
  - FULL: `out_fire` → ONE, main←skid. Otherwise hold. No `in_fire` is possible in this state.
- `in_ready` = (state != FULL). It is a pure function of the state register.
- `out_valid` = (state != EMPTY). `out_data` = main.
- `flush` has priority over every other event:
  - Next state is EMPTY. main and skid are cleared to 0.
  - A simultaneous `in_fire` is dropped.
  - A simultaneous `out_fire` is still a valid transfer for the downstream stage.
- Ordering is strict FIFO. Nothing is duplicated or dropped except by flush.
- A slot that is not updated holds its data.
- Data in an empty slot is 0 after reset or flush. Otherwise it is the last value held, and nothing may depend on it.

## Timing
- Reset: state EMPTY, main=0, skid=0, out_valid=0, out_data=0, in_ready=1, counters=0. The reset takes effect immediately, mid-transfer included, and discards all entries.
- Latency: data accepted at edge N appears on `out_data` with `out_valid`=1 after edge N, so it is available in cycle N+1.
- Sustained rate is 1 transfer per cycle while out_ready=1.
- A single-cycle out_ready drop costs no bubble: the skid absorbs the in-flight word.
- `in_ready` falls in the cycle after the skid fills, and rises in the cycle after the first `out_fire` from FULL.
- `flush` takes effect at the edge: out_valid=0 and in_ready=1 in the next cycle.

## Configuration
- `PIPE_SKID_STAGE_PERF_EN` defined:
  - `stall_cnt` and `flush_cnt` ports and registers exist.
  - Both counters are saturating at 2^CNT_W−1 and reset to 0.
  - `flush_cnt` increments only when flush=1 and state != EMPTY.
  - `stall_cnt` increments on the same cycle as flush if that cycle was stalled.
- Undefined: the counter ports and logic are absent. Handshake behaviour is identical in both builds.

## Structure
- Package `pipe_pkg`: the state enum `pipe_state_e` {PS_EMPTY, PS_ONE, PS_FULL}, 2-bit, and the default counter width `PIPE_CNT_W_DEF`=16.
- Sub-module `pipe_slot #(WIDTH)`:
  - Data register with async reset to 0, synchronous clear, and load enable.
  - Priority is clear over load.
  - Instantiated twice, once for main and once for skid.
- The state machine and the counters live in the top module.

## Test plan
- Reset, then in_valid=1 with data 0x11,0x22,0x33 on consecutive cycles, out_ready=1 → out_data 0x11,0x22,0x33 one cycle later each; in_ready stays 1 throughout.
- Stream 0xA0..0xA3, drop out_ready for cycle 2 only → no loss or duplication; in_ready=0 for exactly one cycle; order is preserved.
- Fill to FULL with 0x5,0x6 and out_ready=0 → in_ready=0 and out_data=0x5 held; raise out_ready → 0x5 then 0x6, then out_valid=0.
- In FULL, assert flush together with in_valid=1 and data 0x77 → next cycle out_valid=0, in_ready=1, 0x77 never appears; with PERF: flush_cnt=1.
- Assert rst asynchronously while in ONE holding 0x9 → out_valid=0 and out_data=0 before the next clock edge, in_ready=1 after release.
- With PERF and CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt saturates at 15; flush in EMPTY → flush_cnt unchanged.
